// File: rtl/cdc_test_pkg.sv
// Shared definitions for the command/response loopback test: sequencer states,
// opcodes, and the payload LFSR and expected-response helpers.
package cdc_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [7:0] OPC_CMD      = 8'h01;
    localparam logic [7:0] OPC_RESP_BIT = 8'h80;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

    function automatic logic [31:0] expected_resp(input logic [7:0] tag, input logic [15:0] payload);
        return {OPC_CMD | OPC_RESP_BIT, tag, ~payload};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload and single-step advance.
module lfsr16
    import cdc_test_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= RESET_VALUE;
        end else if (load) begin
            value_reg <= seed;
        end else if (enable) begin
            value_reg <= lfsr_next(value_reg);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/cmd_test_sequencer.sv
// Issues a run of LFSR-payload commands into the command FIFO under an outstanding
// window, checks every looped-back response in order, and reports the outcome.
module cmd_test_sequencer
    import cdc_test_pkg::*;
#(
    parameter int          NUM_CMDS        = 16,
    parameter int          MAX_OUTSTANDING = 8,
    parameter int          TIMEOUT_CYC     = 4096,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cmd_fifo_full,
    output logic        cmd_fifo_wr_en,
    output logic [31:0] cmd_fifo_wr_data,
    input  logic        resp_fifo_empty,
    input  logic [31:0] resp_fifo_rd_data,
    output logic        resp_fifo_rd_en,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [7:0]  error_count,
    output logic        timeout
);

    localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] NUM_C     = 8'(NUM_CMDS);
    localparam logic [8:0] MAX_OUT_C = 9'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYC);

    seq_state_t    state_reg, state_next;
    logic          start_d_reg;
    logic [7:0]    tx_cnt_reg, rx_cnt_reg, rx_issued_reg;
    logic          rd_valid_reg;
    logic [7:0]    error_count_reg;
    logic          timeout_reg;
    logic [TW-1:0] tmo_cnt_reg;

    logic          start_edge;
    logic          run_load;
    logic          rd_ok;
    logic          tmo_hit;
    logic          compare;
    logic          mismatch;
    logic [8:0]    outstanding;
    logic [15:0]   issue_value, check_value;

    lfsr16 #(.RESET_VALUE(LFSR_SEED)) u_issue_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (cmd_fifo_wr_en),
        .load   (run_load),
        .seed   (LFSR_SEED),
        .value  (issue_value)
    );

    lfsr16 #(.RESET_VALUE(LFSR_SEED)) u_check_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (compare),
        .load   (run_load),
        .seed   (LFSR_SEED),
        .value  (check_value)
    );

    assign start_edge  = start & ~start_d_reg;
    assign outstanding = {1'b0, tx_cnt_reg} - {1'b0, rx_issued_reg};
    // Bounding on accepted reads keeps us from ever popping past the last response.
    assign rd_ok       = !resp_fifo_empty && (rx_issued_reg < NUM_C);
    assign busy        = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done        = (state_reg == ST_DONE);
    assign success     = done && (error_count_reg == 8'd0) && !timeout_reg;
    assign error_count = error_count_reg;
    assign timeout     = timeout_reg;
    assign tmo_hit     = busy && (tmo_cnt_reg == TIMEOUT_C);
    assign compare     = rd_valid_reg && busy;
    assign mismatch    = resp_fifo_rd_data != expected_resp(rx_cnt_reg, check_value);
    assign cmd_fifo_wr_data = cmd_fifo_wr_en ? {OPC_CMD, tx_cnt_reg, issue_value} : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        run_load        = 1'b0;
        cmd_fifo_wr_en  = 1'b0;
        resp_fifo_rd_en = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    state_next = ST_RUN;
                    run_load   = 1'b1;
                end
            end
            ST_RUN: begin
                cmd_fifo_wr_en  = !cmd_fifo_full && (tx_cnt_reg < NUM_C) && (outstanding < MAX_OUT_C);
                resp_fifo_rd_en = rd_ok;
                if (tmo_hit) begin
                    state_next = ST_DONE;
                end else if (tx_cnt_reg == NUM_C) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                resp_fifo_rd_en = rd_ok;
                if (tmo_hit) begin
                    state_next = ST_DONE;
                end else if ((rx_cnt_reg == NUM_C) && !rd_valid_reg) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d_reg     <= 1'b0;
            tx_cnt_reg      <= 8'd0;
            rx_cnt_reg      <= 8'd0;
            rx_issued_reg   <= 8'd0;
            rd_valid_reg    <= 1'b0;
            error_count_reg <= 8'd0;
            timeout_reg     <= 1'b0;
            tmo_cnt_reg     <= '0;
        end else begin
            start_d_reg <= start;
            if (run_load) begin
                tx_cnt_reg      <= 8'd0;
                rx_cnt_reg      <= 8'd0;
                rx_issued_reg   <= 8'd0;
                rd_valid_reg    <= 1'b0;
                error_count_reg <= 8'd0;
                timeout_reg     <= 1'b0;
                tmo_cnt_reg     <= '0;
            end else begin
                if (cmd_fifo_wr_en) begin
                    tx_cnt_reg <= tx_cnt_reg + 8'd1;
                end
                if (resp_fifo_rd_en) begin
                    rx_issued_reg <= rx_issued_reg + 8'd1;
                end
                rd_valid_reg <= resp_fifo_rd_en;
                if (compare) begin
                    rx_cnt_reg <= rx_cnt_reg + 8'd1;
                    if (mismatch && (error_count_reg != 8'hFF)) begin
                        error_count_reg <= error_count_reg + 8'd1;
                    end
                end
                if (cmd_fifo_wr_en || resp_fifo_rd_en) begin
                    tmo_cnt_reg <= '0;
                end else if (busy && !tmo_hit) begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
                if (tmo_hit) begin
                    timeout_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_test_sequencer.sv
// Self-checking bench: behavioural FIFO/responder model plus a spec-level command reference.
module tb_cmd_test_sequencer;

    localparam int N    = 16;
    localparam int MAXO = 8;
    localparam int TMO  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        cmd_fifo_full = 1'b0;
    logic        cmd_fifo_wr_en;
    logic [31:0] cmd_fifo_wr_data;
    logic        resp_fifo_empty = 1'b1;
    logic [31:0] resp_fifo_rd_data = 32'd0;
    logic        resp_fifo_rd_en;
    logic        busy, done, success, timeout;
    logic [7:0]  error_count;

    cmd_test_sequencer #(
        .NUM_CMDS(N), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYC(TMO), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmd_fifo_full(cmd_fifo_full), .cmd_fifo_wr_en(cmd_fifo_wr_en),
        .cmd_fifo_wr_data(cmd_fifo_wr_data), .resp_fifo_empty(resp_fifo_empty),
        .resp_fifo_rd_data(resp_fifo_rd_data), .resp_fifo_rd_en(resp_fifo_rd_en),
        .busy(busy), .done(done), .success(success),
        .error_count(error_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Environment model state
    logic [31:0] cmd_log[$];
    logic [31:0] resp_q[$];
    logic [31:0] fl_w[$];
    int          fl_due[$];
    int          writes, reads, max_out, cyc, last_wr_cyc;
    int          full_viol, empty_viol;
    int          latency = 20;
    int          full_pct = 0;
    int          empty_pct = 0;
    bit          force_full = 1'b0;
    bit          respond_en = 1'b1;
    int          corrupt_tag = -1;
    logic [31:0] first_resp;
    bit          first_resp_seen;

    // Payload k of a run: the seed advanced k times by the tap-16/14/13/11 shift rule.
    function automatic logic [31:0] ref_cmd(input int k);
        int v = 'hACE1;
        int fb;
        for (int i = 0; i < k; i++) begin
            fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
            v  = (v >> 1) | (fb << 15);
        end
        return {8'h01, 8'(k), 16'(v)};
    endfunction

    task automatic reset_model();
        cmd_log.delete(); resp_q.delete(); fl_w.delete(); fl_due.delete();
        writes = 0; reads = 0; max_out = 0; last_wr_cyc = 0;
        full_viol = 0; empty_viol = 0;
        first_resp_seen = 1'b0; first_resp = 32'd0;
        force_full = 1'b0; full_pct = 0; empty_pct = 0;
        respond_en = 1'b1; corrupt_tag = -1;
    endtask

    // FIFO pair + responder: strobes sampled mid-cycle, flags updated just after each edge.
    initial begin
        logic        sw, sr;
        logic [31:0] sd, w;
        cyc = 0;
        reset_model();
        forever begin
            @(negedge clk);
            sw = cmd_fifo_wr_en; sd = cmd_fifo_wr_data; sr = resp_fifo_rd_en;
            if (sw && cmd_fifo_full) full_viol++;
            if (sr && resp_fifo_empty) empty_viol++;
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n) begin
                if (sw) begin
                    cmd_log.push_back(sd);
                    writes++;
                    last_wr_cyc = cyc;
                    $display("cyc %0d cmd write #%0d word=%h", cyc, writes - 1, sd);
                    if (respond_en) begin
                        w = {sd[31:24] | 8'h80, sd[23:16], ~sd[15:0]};
                        if (int'(sd[23:16]) == corrupt_tag) w[0] = ~w[0];
                        fl_w.push_back(w);
                        fl_due.push_back(cyc + latency);
                    end
                end
                if (sr) begin
                    if (resp_q.size() > 0) resp_fifo_rd_data = resp_q.pop_front();
                    reads++;
                    $display("cyc %0d resp read #%0d word=%h", cyc, reads - 1, resp_fifo_rd_data);
                end
                while (fl_due.size() > 0 && fl_due[0] <= cyc) begin
                    void'(fl_due.pop_front());
                    w = fl_w.pop_front();
                    if (!first_resp_seen) begin
                        first_resp = w;
                        first_resp_seen = 1'b1;
                    end
                    resp_q.push_back(w);
                end
                if (writes - reads > max_out) max_out = writes - reads;
            end
            cmd_fifo_full   = force_full || ($urandom_range(0, 99) < full_pct);
            resp_fifo_empty = (resp_q.size() == 0) || ($urandom_range(0, 99) < empty_pct);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit fin);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        fin = done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, success, timeout, cmd_fifo_wr_en, resp_fifo_rd_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000", {busy, done, success, timeout, cmd_fifo_wr_en, resp_fifo_rd_en});
        end
        checks++;
        if (error_count !== 8'd0 || cmd_fifo_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_values err=%0d data=%h want 0/0", error_count, cmd_fifo_wr_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_clean();
        bit fin;
        reset_model();
        latency = 20;
        pulse_start();
        wait_done(3000, fin);
        checks++;
        if (!fin) begin errors++; $display("FAIL clean_done_wait got=0 want=1"); end
        checks++;
        if (cmd_log.size() != N) begin errors++; $display("FAIL clean_writes got=%0d want=%0d", cmd_log.size(), N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (cmd_log[k] !== ref_cmd(k)) begin
                errors++;
                $display("FAIL clean_cmd[%0d] got=%h want=%h", k, cmd_log[k], ref_cmd(k));
            end
        end
        checks++;
        if (cmd_log[0] !== 32'h0100ACE1) begin errors++; $display("FAIL first_word got=%h want=0100ace1", cmd_log[0]); end
        checks++;
        if (first_resp !== 32'h8100531E) begin errors++; $display("FAIL first_resp got=%h want=8100531e", first_resp); end
        checks++;
        if (success !== 1'b1 || error_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_status success=%b err=%0d busy=%b want 1/0/0", success, error_count, busy);
        end
        checks++;
        if (reads != N) begin errors++; $display("FAIL clean_reads got=%0d want=%0d", reads, N); end
        checks++;
        if (max_out != MAXO) begin errors++; $display("FAIL clean_window got=%0d want=%0d", max_out, MAXO); end
        checks++;
        if (full_viol + empty_viol != 0) begin errors++; $display("FAIL clean_flags full_viol=%0d empty_viol=%0d want 0", full_viol, empty_viol); end
    endtask

    task automatic test_full_stall();
        bit fin;
        int w0;
        reset_model();
        latency = int'($urandom_range(5, 30));
        pulse_start();
        for (int i = 0; i < 200 && writes < 4; i++) @(negedge clk);
        force_full = 1'b1;
        @(negedge clk);
        w0 = writes;
        repeat (50) @(negedge clk);
        checks++;
        if (writes != w0) begin errors++; $display("FAIL stall_writes got=%0d want=%0d", writes, w0); end
        force_full = 1'b0;
        wait_done(3000, fin);
        checks++;
        if (!fin || success !== 1'b1) begin errors++; $display("FAIL stall_status done=%b success=%b want 1/1", fin, success); end
        checks++;
        if (full_viol != 0) begin errors++; $display("FAIL stall_full_viol got=%0d want=0", full_viol); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (cmd_log[k] !== ref_cmd(k)) begin
                errors++;
                $display("FAIL stall_cmd[%0d] got=%h want=%h", k, cmd_log[k], ref_cmd(k));
            end
        end
    endtask

    task automatic test_no_response();
        bit fin;
        int elapsed;
        reset_model();
        respond_en = 1'b0;
        pulse_start();
        wait_done(TMO + 500, fin);
        elapsed = cyc - last_wr_cyc;
        checks++;
        if (writes != MAXO) begin errors++; $display("FAIL norsp_writes got=%0d want=%0d", writes, MAXO); end
        checks++;
        if (!fin || timeout !== 1'b1 || success !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL norsp_status done=%b timeout=%b success=%b busy=%b want 1/1/0/0", fin, timeout, success, busy);
        end
        checks++;
        if (elapsed < TMO - 4 || elapsed > TMO + 8) begin
            errors++;
            $display("FAIL norsp_timeout_len got=%0d want about %0d", elapsed, TMO);
        end
        respond_en = 1'b1;
    endtask

    task automatic test_corrupt();
        bit fin;
        reset_model();
        latency = int'($urandom_range(1, 40));
        corrupt_tag = 5;
        pulse_start();
        wait_done(3000, fin);
        checks++;
        if (!fin || error_count !== 8'd1 || success !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_status done=%b err=%0d success=%b timeout=%b want 1/1/0/0", fin, error_count, success, timeout);
        end
        checks++;
        if (reads != N) begin errors++; $display("FAIL corrupt_reads got=%0d want=%0d", reads, N); end
        corrupt_tag = -1;
    endtask

    task automatic test_reset_mid();
        bit fin;
        reset_model();
        latency = 30;
        pulse_start();
        for (int i = 0; i < 1000 && !(writes == N && reads >= N - 3); i++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || writes != N) begin errors++; $display("FAIL midrst_pre busy=%b writes=%0d want 1/%0d", busy, writes, N); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, success, timeout, cmd_fifo_wr_en, resp_fifo_rd_en} !== 6'b0 || error_count !== 8'd0 || cmd_fifo_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL midrst_async flags=%b err=%0d data=%h want all 0",
                     {busy, done, success, timeout, cmd_fifo_wr_en, resp_fifo_rd_en}, error_count, cmd_fifo_wr_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_model();
        latency = int'($urandom_range(1, 40));
        pulse_start();
        wait_done(3000, fin);
        checks++;
        if (!fin || success !== 1'b1 || cmd_log.size() != N || cmd_log[0] !== 32'h0100ACE1) begin
            errors++;
            $display("FAIL midrst_rerun done=%b success=%b writes=%0d first=%h want 1/1/%0d/0100ace1", fin, success, cmd_log.size(), cmd_log[0], N);
        end
    endtask

    task automatic test_random();
        bit fin;
        for (int r = 0; r < 3; r++) begin
            reset_model();
            latency   = int'($urandom_range(1, 40));
            full_pct  = int'($urandom_range(0, 40));
            empty_pct = int'($urandom_range(0, 40));
            pulse_start();
            wait_done(6000, fin);
            checks++;
            if (!fin || success !== 1'b1 || reads != N) begin
                errors++;
                $display("FAIL rand%0d_status done=%b success=%b reads=%0d want 1/1/%0d", r, fin, success, reads, N);
            end
            checks++;
            if (max_out > MAXO || full_viol != 0 || empty_viol != 0) begin
                errors++;
                $display("FAIL rand%0d_bounds max_out=%0d full_viol=%0d empty_viol=%0d want <=%0d/0/0", r, max_out, full_viol, empty_viol, MAXO);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (cmd_log[k] !== ref_cmd(k)) begin
                    errors++;
                    $display("FAIL rand%0d_cmd[%0d] got=%h want=%h", r, k, cmd_log[k], ref_cmd(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit fin;
        int w0;
        reset_model();
        latency = int'($urandom_range(5, 25));
        pulse_start();
        for (int i = 0; i < 200 && writes < 5; i++) @(negedge clk);
        pulse_start();
        wait_done(3000, fin);
        checks++;
        if (!fin || success !== 1'b1 || cmd_log.size() != N) begin
            errors++;
            $display("FAIL b2b_ignore done=%b success=%b writes=%0d want 1/1/%0d", fin, success, cmd_log.size(), N);
        end
        w0 = writes;
        repeat (10) @(negedge clk);
        checks++;
        if (done !== 1'b1 || writes != w0) begin errors++; $display("FAIL b2b_hold done=%b writes=%0d want 1/%0d", done, writes, w0); end
        for (int r = 0; r < 2; r++) begin
            reset_model();
            latency = int'($urandom_range(1, 30));
            pulse_start();
            wait_done(3000, fin);
            checks++;
            if (!fin || success !== 1'b1 || cmd_log.size() != N) begin
                errors++;
                $display("FAIL b2b_run%0d done=%b success=%b writes=%0d want 1/1/%0d", r, fin, success, cmd_log.size(), N);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (cmd_log[k] !== ref_cmd(k)) begin
                    errors++;
                    $display("FAIL b2b_run%0d_cmd[%0d] got=%h want=%h", r, k, cmd_log[k], ref_cmd(k));
                end
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_clean();
        test_full_stall();
        test_no_response();
        test_corrupt();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
